adder_share_ctrl: RTL

Sequencer and arbiter that shares one 32-bit ripple-carry adder (ripcarryadder) between two requesters. It performs 32-bit add/sub in one adder pass and 64-bit add/sub in two passes, chaining the carry through a register. Requests and responses use valid/ready handshakes. It sits between the ALU/address-generation clients and the single shared adder instance.

---
 rtl/adder_share_pkg.sv | 24 ++
 rtl/adder_share_ctrl_arb.sv | 37 +++
 rtl/ripcarryadder.sv | 27 ++
 rtl/adder_share_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/adder_share_pkg.sv
// Shared encodings for the shared-adder controller: op codes, FSM states and the
// overflow helper used on the top word of every result.
package adder_share_pkg;

    localparam int WORD_W = 32;

    localparam logic [1:0] OP_ADD32 = 2'b00;
    localparam logic [1:0] OP_SUB32 = 2'b01;
    localparam logic [1:0] OP_ADD64 = 2'b10;
    localparam logic [1:0] OP_SUB64 = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LO   = 2'b01,
        HI   = 2'b10,
        RESP = 2'b11
    } state_t;

    // Signed overflow: operands agree in sign but the sum does not.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/adder_share_ctrl_arb.sv
// Two-input round-robin arbiter; the pointer names the requester that wins a tie and
// flips to the loser of each advanced grant.
module rr_arb2 #(
    parameter int RR_INIT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid_i,
    input  logic       advance_i,
    output logic [1:0] grant_o
);

    logic ptr_q;

    // Grant decode: a lone requester always wins, a tie goes to the pointer.
    always_comb begin
        grant_o = 2'b00;
        case (valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = ptr_q ? 2'b10 : 2'b01;
            default: grant_o = 2'b00;
        endcase
    end

    // Pointer register: after a grant, priority passes to the other requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= (RR_INIT != 0) ? 1'b1 : 1'b0;
        end else if (advance_i) begin
            ptr_q <= grant_o[0];
        end else begin
            ptr_q <= ptr_q;
        end
    end

endmodule

// File: rtl/ripcarryadder.sv
// Plain W-bit ripple-carry adder; the single arithmetic resource shared by the controller.
module ripcarryadder #(
    parameter int W = 32
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);

    logic [W:0] c_s;

    // Bit-serial carry chain.
    always_comb begin
        c_s    = '0;
        sum_o  = '0;
        c_s[0] = cin_i;
        for (int i = 0; i < W; i++) begin
            sum_o[i]   = a_i[i] ^ b_i[i] ^ c_s[i];
            c_s[i + 1] = (a_i[i] & b_i[i]) | (c_s[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign cout_o = c_s[W];

endmodule

// File: rtl/adder_share_ctrl.sv
// Sequences 32/64-bit add/sub from two requesters through one 32-bit ripple adder;
// 64-bit ops take a low pass and a high pass with the carry held in a register.
module adder_share_ctrl
    import adder_share_pkg::*;
#(
    parameter int DBL_EN  = 1,
    parameter int RR_INIT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [1:0]  req0_op,
    input  logic [63:0] req0_a,
    input  logic [63:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [1:0]  req1_op,
    input  logic [63:0] req1_a,
    input  logic [63:0] req1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [63:0] rsp_sum,
    output logic        rsp_cout,
    output logic        rsp_ovf
);

    localparam logic DBL_L = (DBL_EN != 0) ? 1'b1 : 1'b0;

    state_t      state_q;
    logic [1:0]  op_q;
    logic [63:0] a_q, b_q, sum_q;
    logic        id_q, carry_q, cout_q, ovf_q, rsp_valid_q;

    logic [1:0]        grant_s;
    logic              accept_s, sub_s, ovf_s, add_cin_s, add_cout_s;
    logic [1:0]        sel_op_s;
    logic [63:0]       sel_a_s, sel_b_s;
    logic [WORD_W-1:0] add_a_s, add_b_s, add_sum_s;

    assign accept_s   = (state_q == IDLE) && (grant_s != 2'b00);
    assign req0_ready = rst_n && (state_q == IDLE) && grant_s[0];
    assign req1_ready = rst_n && (state_q == IDLE) && grant_s[1];
    assign sub_s      = op_q[0];

    rr_arb2 #(.RR_INIT(RR_INIT)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_i   ({req1_valid, req0_valid}),
        .advance_i (accept_s),
        .grant_o   (grant_s)
    );

    // Request mux for the granted requester.
    always_comb begin
        if (grant_s[1]) begin
            sel_op_s = req1_op;
            sel_a_s  = req1_a;
            sel_b_s  = req1_b;
        end else begin
            sel_op_s = req0_op;
            sel_a_s  = req0_a;
            sel_b_s  = req0_b;
        end
    end

    // Adder operand mux, fed only from latched operands; sub inverts B and injects +1.
    always_comb begin
        if (state_q == HI) begin
            add_a_s   = a_q[2*WORD_W-1:WORD_W];
            add_b_s   = b_q[2*WORD_W-1:WORD_W] ^ {WORD_W{sub_s}};
            add_cin_s = carry_q;
        end else begin
            add_a_s   = a_q[WORD_W-1:0];
            add_b_s   = b_q[WORD_W-1:0] ^ {WORD_W{sub_s}};
            add_cin_s = sub_s;
        end
    end

    ripcarryadder #(.W(WORD_W)) u_add (
        .a_i    (add_a_s),
        .b_i    (add_b_s),
        .cin_i  (add_cin_s),
        .sum_o  (add_sum_s),
        .cout_o (add_cout_s)
    );

    assign ovf_s = add_ovf(add_a_s[WORD_W-1], add_b_s[WORD_W-1], add_sum_s[WORD_W-1]);

    // Controller FSM with all result outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= 2'b00;
            a_q         <= 64'h0;
            b_q         <= 64'h0;
            sum_q       <= 64'h0;
            id_q        <= 1'b0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        id_q    <= grant_s[1];
                        op_q    <= {sel_op_s[1] & DBL_L, sel_op_s[0]};
                        a_q     <= sel_a_s;
                        b_q     <= sel_b_s;
                        state_q <= LO;
                    end
                end
                LO: begin
                    sum_q[WORD_W-1:0] <= add_sum_s;
                    carry_q           <= add_cout_s;
                    if (op_q[1]) begin
                        state_q <= HI;
                    end else begin
                        sum_q[2*WORD_W-1:WORD_W] <= {WORD_W{1'b0}};
                        cout_q      <= add_cout_s;
                        ovf_q       <= ovf_s;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                HI: begin
                    sum_q[2*WORD_W-1:WORD_W] <= add_sum_s;
                    cout_q      <= add_cout_s;
                    ovf_q       <= ovf_s;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;
    assign rsp_cout  = cout_q;
    assign rsp_ovf   = ovf_q;

endmodule
